// File: rtl/tick_pkg.sv
// tick_pkg: shared mode codes, default-width config type and cfg_ch width helper.
//   Users: prog_tick_gen_if, tick_channel, prog_tick_gen (import tick_pkg::*).
package tick_pkg;
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;
    localparam int   TICK_W        = 8;
    typedef struct packed {
        logic [TICK_W-1:0] div;
        logic              mode;
    } tick_cfg_t;
    function automatic int ch_w(input int nch);
        return nch > 1 ? $clog2(nch) : 1;
    endfunction
endpackage

// File: rtl/prog_tick_gen_if.sv
// prog_tick_gen_if: config/control/status bundle of prog_tick_gen.
//   master drives cfg_we, cfg_ch, cfg_div, cfg_mode, start, stop; reads tick, busy, cfg_pend.
//   slave is the generator side.
interface prog_tick_gen_if import tick_pkg::*; #(
    parameter int NCH = 4,
    parameter int W   = 8
);
    localparam int CW = ch_w(NCH);
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [W-1:0]   cfg_div;
    logic           cfg_mode;
    logic [NCH-1:0] start;
    logic [NCH-1:0] stop;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] cfg_pend;
    modport master (
        output cfg_we, cfg_ch, cfg_div, cfg_mode, start, stop,
        input  tick, busy, cfg_pend
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_div, cfg_mode, start, stop,
        output tick, busy, cfg_pend
    );
endinterface

// File: rtl/tick_channel.sv
// tick_channel: one programmable tick counter with shadow/active config.
//   in:  clk, rst, we (write to this channel), cfg_div, cfg_mode, start, stop
//   out: tick (one-cycle strobe), busy (running), pend (shadow awaiting apply)
module tick_channel import tick_pkg::*; #(
    parameter int W       = 8,
    parameter int RST_DIV = 255,
    parameter int RST_RUN = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         we,
    input  logic [W-1:0] cfg_div,
    input  logic         cfg_mode,
    input  logic         start,
    input  logic         stop,
    output logic         tick,
    output logic         busy,
    output logic         pend
);
    typedef struct packed {
        logic [W-1:0] div;
        logic         mode;
    } cfg_t;
    cfg_t         act, shd, nxt;
    logic [W-1:0] count;
    logic         pend_any, wrap, apply, clr;
    // A write on the same edge as an apply point takes effect directly.
    always_comb begin
        nxt      = we ? cfg_t'{div: cfg_div, mode: cfg_mode} : shd;
        pend_any = we | pend;
        wrap     = busy && count == act.div;
        clr      = !busy || start || stop || wrap;
        apply    = pend_any && clr;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            act   <= '{div: W'(RST_DIV), mode: MODE_PERIODIC};
            shd   <= '{div: W'(RST_DIV), mode: MODE_PERIODIC};
            busy  <= RST_RUN != 0;
            tick  <= 1'b0;
            pend  <= 1'b0;
        end else begin
            shd   <= nxt;
            if (apply) act <= nxt;
            pend  <= pend_any && !apply;
            tick  <= wrap && !start && !stop;
            count <= clr ? '0 : count + W'(1);
            // One-shot termination uses the mode of the period that just ended.
            busy  <= stop ? 1'b0 : start ? 1'b1 : (wrap && act.mode == MODE_ONESHOT) ? 1'b0 : busy;
        end
    end
endmodule

// File: rtl/prog_tick_gen.sv
// prog_tick_gen: NCH runtime-programmable clock-enable tick generators.
//   in:  clk, rst; bus.cfg_we/cfg_ch/cfg_div/cfg_mode, bus.start, bus.stop
//   out: bus.tick, bus.busy, bus.cfg_pend (all registered)
module prog_tick_gen import tick_pkg::*; #(
    parameter int NCH     = 4,
    parameter int W       = 8,
    parameter int RST_DIV = 255,
    parameter int RST_RUN = 1
) (
    input logic             clk,
    input logic             rst,
    prog_tick_gen_if.slave  bus
);
    localparam int CW = ch_w(NCH);
    // Addresses at or above NCH match no channel, so such writes are dropped.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tick_channel #(.W(W), .RST_DIV(RST_DIV), .RST_RUN(RST_RUN)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .we       (bus.cfg_we && bus.cfg_ch == CW'(i)),
            .cfg_div  (bus.cfg_div),
            .cfg_mode (bus.cfg_mode),
            .start    (bus.start[i]),
            .stop     (bus.stop[i]),
            .tick     (bus.tick[i]),
            .busy     (bus.busy[i]),
            .pend     (bus.cfg_pend[i])
        );
    end
endmodule
